// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
// The counter width covers the lock timeout, the stable window and the release stagger span.
package pll_seq_pkg;

  localparam int NUM_DOMAINS = 5;

  typedef enum logic [2:0] {
    HOLD,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN
  } seq_state_e;

  // One shared counter serves every state, so it must hold the largest terminal count.
  function automatic int cnt_width(input int timeout_cycles,
                                   input int stable_cycles,
                                   input int stagger_cycles);
    int max_val;
    max_val = timeout_cycles;
    if (stable_cycles > max_val) max_val = stable_cycles;
    if ((NUM_DOMAINS - 1) * stagger_cycles + 1 > max_val)
      max_val = (NUM_DOMAINS - 1) * stagger_cycles + 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous PLL lock indication into the refclk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Pulses the PLL reset, waits for a stable lock, then releases the output-clock domain
// resets one by one; re-runs the whole sequence on lock loss, timeout or soft request.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PULSE_CYCLES        = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 500000,
  parameter int STAGGER_CYCLES      = 8
) (
  input  logic                   refclk,
  input  logic                   rst,
  input  logic                   pll_locked,
  input  logic                   soft_req,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   ready,
  output logic [7:0]             relock_count,
  output logic                   timeout_err
);

  localparam int CW = cnt_width(LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES, STAGGER_CYCLES);

  localparam logic [CW-1:0] PULSE_LAST   = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] REL_DONE     = CW'((NUM_DOMAINS - 1) * STAGGER_CYCLES);

  seq_state_e             state;
  seq_state_e             state_nx;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_nx;
  logic                   lk_s;
  logic                   relock_inc;
  logic                   timeout_hit;
  logic [NUM_DOMAINS-1:0] domain_nx;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk_s)
  );

  // Lock loss in RUN wins over a coincident soft request so it is still counted.
  always_comb begin
    state_nx    = state;
    relock_inc  = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      HOLD: begin
        if (cnt == PULSE_LAST) state_nx = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (!lk_s && cnt == TIMEOUT_LAST) begin
          state_nx    = HOLD;
          timeout_hit = 1'b1;
        end else if (soft_req) begin
          state_nx = HOLD;
        end else if (lk_s) begin
          state_nx = STABLE;
        end
      end
      STABLE: begin
        if (soft_req)                 state_nx = HOLD;
        else if (!lk_s)               state_nx = WAIT_LOCK;
        else if (cnt == STABLE_LAST)  state_nx = RELEASE;
      end
      RELEASE: begin
        if (soft_req || !lk_s)        state_nx = HOLD;
        else if (cnt == REL_DONE)     state_nx = RUN;
      end
      RUN: begin
        if (!lk_s) begin
          state_nx   = HOLD;
          relock_inc = 1'b1;
        end else if (soft_req) begin
          state_nx = HOLD;
        end
      end
      default: state_nx = HOLD;
    endcase
  end

  // Counter restarts on any state change and idles in RUN, where it has no job.
  always_comb begin
    cnt_nx = cnt + CW'(1);
    if (state_nx != state)  cnt_nx = '0;
    else if (state == RUN)  cnt_nx = cnt;
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_comb begin
    domain_nx = '1;
    if (state_nx == RELEASE) begin
      for (int i = 0; i < NUM_DOMAINS; i++)
        domain_nx[i] = (cnt_nx < CW'(i * STAGGER_CYCLES));
    end else if (state_nx == RUN) begin
      domain_nx = '0;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state        <= HOLD;
      cnt          <= '0;
      pll_rst      <= 1'b1;
      domain_rst   <= '1;
      ready        <= 1'b0;
      relock_count <= 8'd0;
      timeout_err  <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      pll_rst    <= (state_nx == HOLD);
      domain_rst <= domain_nx;
      ready      <= (state_nx == RUN);
      if (relock_inc && relock_count != 8'hFF) relock_count <= relock_count + 8'd1;
      if (timeout_hit) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short timing parameters; every expected
// value is a hand-derived edge count relative to the stimulus that triggers it.
module tb_pll_reset_sequencer;

  logic       refclk;
  logic       rst;
  logic       pll_locked;
  logic       soft_req;
  logic       pll_rst;
  logic [4:0] domain_rst;
  logic       ready;
  logic [7:0] relock_count;
  logic       timeout_err;

  int passes = 0;
  int total  = 0;

  localparam logic [4:0] REL_EXP [10] = '{5'h1E, 5'h1E, 5'h1C, 5'h1C, 5'h18,
                                          5'h18, 5'h10, 5'h10, 5'h00, 5'h00};

  pll_reset_sequencer #(
    .PULSE_CYCLES        (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32),
    .STAGGER_CYCLES      (2)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .soft_req     (soft_req),
    .pll_rst      (pll_rst),
    .domain_rst   (domain_rst),
    .ready        (ready),
    .relock_count (relock_count),
    .timeout_err  (timeout_err)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic applyStimulus(input logic r, input logic lk, input logic sr);
    rst        = r;
    pll_locked = lk;
    soft_req   = sr;
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // Lock drop in RUN, optionally with a soft request landing on the same decision edge.
  task automatic lossCycle(input logic with_soft, input int exp_count);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(2);
    checkOutput("loss_domain_pre", 32'(domain_rst), 32'h00);
    applyStimulus(1'b0, 1'b0, with_soft);
    tick(1);
    checkOutput("loss_domain", 32'(domain_rst), 32'h1F);
    checkOutput("loss_ready", 32'(ready), 32'd0);
    checkOutput("loss_relock", 32'(relock_count), 32'(exp_count));
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(22);
    checkOutput("relock_ready", 32'(ready), 32'd1);
  endtask

  initial begin
    $display("[TB] start");
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick(1);
    checkOutput("reset_pll_rst", 32'(pll_rst), 32'd1);
    checkOutput("reset_domain", 32'(domain_rst), 32'h1F);
    checkOutput("reset_ready", 32'(ready), 32'd0);
    checkOutput("reset_relock", 32'(relock_count), 32'd0);
    checkOutput("reset_timeout", 32'(timeout_err), 32'd0);

    // Nominal bring-up
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(1);
    checkOutput("pulse_1", 32'(pll_rst), 32'd1);
    tick(2);
    checkOutput("pulse_3", 32'(pll_rst), 32'd1);
    tick(1);
    checkOutput("pulse_end", 32'(pll_rst), 32'd0);
    checkOutput("wait_domain", 32'(domain_rst), 32'h1F);
    tick(5);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(10);
    checkOutput("pre_release_domain", 32'(domain_rst), 32'h1F);
    checkOutput("pre_release_ready", 32'(ready), 32'd0);
    for (int k = 0; k < 10; k++) begin
      tick(1);
      checkOutput($sformatf("rel_domain_%0d", k), 32'(domain_rst), 32'(REL_EXP[k]));
      checkOutput($sformatf("rel_ready_%0d", k), 32'(ready), (k == 9) ? 32'd1 : 32'd0);
    end
    checkOutput("run_pll_rst", 32'(pll_rst), 32'd0);

    // Soft request alone, then a one-cycle lock glitch in STABLE
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick(1);
    checkOutput("soft_pll_rst", 32'(pll_rst), 32'd1);
    checkOutput("soft_domain", 32'(domain_rst), 32'h1F);
    checkOutput("soft_ready", 32'(ready), 32'd0);
    checkOutput("soft_relock", 32'(relock_count), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(3);
    checkOutput("soft_pulse_3", 32'(pll_rst), 32'd1);
    tick(1);
    checkOutput("soft_pulse_end", 32'(pll_rst), 32'd0);
    tick(6);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(2);
    checkOutput("glitch_no_release", 32'(domain_rst), 32'h1F);
    tick(8);
    checkOutput("glitch_still_held", 32'(domain_rst), 32'h1F);
    tick(1);
    checkOutput("glitch_release", 32'(domain_rst), 32'h1E);
    tick(9);
    checkOutput("glitch_ready", 32'(ready), 32'd1);

    // Lock timeout
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick(1);
    checkOutput("to_hold_pll_rst", 32'(pll_rst), 32'd1);
    checkOutput("to_hold_relock", 32'(relock_count), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(4);
    checkOutput("to_wait_pll_rst", 32'(pll_rst), 32'd0);
    tick(31);
    checkOutput("to_before_flag", 32'(timeout_err), 32'd0);
    checkOutput("to_before_pll_rst", 32'(pll_rst), 32'd0);
    tick(1);
    checkOutput("to_flag", 32'(timeout_err), 32'd1);
    checkOutput("to_repulse", 32'(pll_rst), 32'd1);
    tick(3);
    checkOutput("to_repulse_3", 32'(pll_rst), 32'd1);
    tick(1);
    checkOutput("to_repulse_end", 32'(pll_rst), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(19);
    checkOutput("to_ready_early", 32'(ready), 32'd0);
    tick(1);
    checkOutput("to_ready", 32'(ready), 32'd1);
    checkOutput("to_flag_sticky", 32'(timeout_err), 32'd1);

    // Soft request coincident with lock loss counts once, then saturation
    lossCycle(1'b1, 1);
    for (int i = 0; i < 300; i++) begin
      int exp_count;
      exp_count = i + 2;
      if (exp_count > 255) exp_count = 255;
      lossCycle(1'b0, exp_count);
    end
    checkOutput("sat_relock", 32'(relock_count), 32'd255);
    checkOutput("sat_timeout_sticky", 32'(timeout_err), 32'd1);

    // rst during RELEASE after two domains released
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(13);
    checkOutput("mid_rel_0", 32'(domain_rst), 32'h1E);
    tick(2);
    checkOutput("mid_rel_2", 32'(domain_rst), 32'h1C);
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick(1);
    checkOutput("mid_rst_domain", 32'(domain_rst), 32'h1F);
    checkOutput("mid_rst_pll_rst", 32'(pll_rst), 32'd1);
    checkOutput("mid_rst_ready", 32'(ready), 32'd0);
    checkOutput("mid_rst_relock", 32'(relock_count), 32'd0);
    checkOutput("mid_rst_timeout", 32'(timeout_err), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(1);
    checkOutput("mid_pulse_3", 32'(pll_rst), 32'd1);
    tick(1);
    checkOutput("mid_pulse_end", 32'(pll_rst), 32'd0);
    tick(17);
    checkOutput("mid_ready_early", 32'(ready), 32'd0);
    tick(1);
    checkOutput("mid_ready", 32'(ready), 32'd1);
    checkOutput("mid_timeout_clear", 32'(timeout_err), 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
